// File: rtl/mul_sequencer_if.sv
// Operand/result bundle between EXE-stage control and the multiply sequencer.
// master = pipeline side (drives operands), slave = sequencer.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             flush;
  logic             accumulate;
  logic             s_bit;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc_in;
  logic [3:0]       dest_in;
  logic [3:0]       status_in;
  logic             busy;
  logic             freeze;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       dest_out;
  logic [3:0]       status_bits;
  logic             status_we;

  modport master (
    output start, flush, accumulate, s_bit,
    output op_a, op_b, acc_in, dest_in, status_in,
    input  busy, freeze, done, result,
    input  dest_out, status_bits, status_we
  );

  modport slave (
    input  start, flush, accumulate, s_bit,
    input  op_a, op_b, acc_in, dest_in, status_in,
    output busy, freeze, done, result,
    output dest_out, status_bits, status_we
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add MUL/MLA sequencer; freezes the pipeline while running.
// Ports: clk, rst (async active-low), bus (mul_sequencer_if.slave).
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  mul_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [3:0]       dest_q, dest_d;
  logic             s_q, s_d;
  logic [1:0]       cv_q, cv_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       dout_q, dout_d;
  logic [3:0]       stb_q, stb_d;

  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] mplier_sh;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] acc_init;
  logic             accept;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    dest_d    = dest_q;
    s_d       = s_q;
    cv_d      = cv_q;
    res_d     = res_q;
    dout_d    = dout_q;
    stb_d     = stb_q;
    acc_nx    = mplier_q[0] ? acc_q + mcand_q : acc_q;
    mplier_sh = mplier_q >> 1;
    cnt_nx    = cnt_q + CW'(1);
    acc_init  = bus.accumulate ? bus.acc_in : '0;
    accept    = (state_q == IDLE) && bus.start && !bus.flush;

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_d    = acc_init;
            mcand_d  = bus.op_a;
            mplier_d = bus.op_b;
            cnt_d    = '0;
            dest_d   = bus.dest_in;
            s_d      = bus.s_bit;
            cv_d     = bus.status_in[1:0];
            if (bus.op_b == '0) begin
              state_d = DONE;
              res_d   = acc_init;
              dout_d  = bus.dest_in;
              stb_d   = {acc_init[WIDTH-1],
                         acc_init == '0,
                         bus.status_in[1:0]};
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          acc_d    = acc_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_sh;
          cnt_d    = cnt_nx;
          if (mplier_sh == '0 ||
              cnt_nx == CW'(WIDTH)) begin
            state_d = DONE;
            res_d   = acc_nx;
            dout_d  = dest_q;
            stb_d   = {acc_nx[WIDTH-1],
                       acc_nx == '0, cv_q};
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      dest_q   <= '0;
      s_q      <= 1'b0;
      cv_q     <= '0;
      res_q    <= '0;
      dout_q   <= '0;
      stb_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      dest_q   <= dest_d;
      s_q      <= s_d;
      cv_q     <= cv_d;
      res_q    <= res_d;
      dout_q   <= dout_d;
      stb_q    <= stb_d;
    end
  end

  // A flush landing on the DONE cycle must still suppress the
  // result pulse, so done is gated by the live flush input.
  assign bus.busy        = (state_q != IDLE);
  assign bus.freeze      = accept || (state_q == RUN);
  assign bus.done        = (state_q == DONE) && !bus.flush;
  assign bus.status_we   = bus.done && s_q;
  assign bus.result      = res_q;
  assign bus.dest_out    = dout_q;
  assign bus.status_bits = stb_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomised and directed bench for mul_sequencer with a
// transaction-level reference model and a per-cycle compare process.
module tb_mul_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(32)) bus ();

  mul_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted op produces its result k edges after
  // acceptance, k = position of op_b's highest set bit (0 if op_b==0).
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  int          m_state = M_IDLE;
  int          m_left  = 0;
  logic [31:0] p_res;
  logic [3:0]  p_dest;
  logic [3:0]  p_stb;
  logic [31:0] m_res  = '0;
  logic [3:0]  m_dest = '0;
  logic [3:0]  m_stb  = '0;
  logic        m_s    = 1'b0;

  function automatic int kbits(input logic [31:0] b);
    for (int i = 31; i >= 0; i--)
      if (b[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] c,
                                          input logic acc);
    logic [63:0] p;
    p = 64'(a) * 64'(b) + (acc ? 64'(c) : 64'd0);
    return p[31:0];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = M_IDLE;
      m_left  = 0;
      m_res   = '0;
      m_dest  = '0;
      m_stb   = '0;
      m_s     = 1'b0;
    end else if (bus.flush) begin
      m_state = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: if (bus.start) begin
          p_res  = ref_mul(bus.op_a, bus.op_b,
                           bus.acc_in, bus.accumulate);
          p_dest = bus.dest_in;
          p_stb  = {p_res[31], p_res == 0,
                    bus.status_in[1:0]};
          m_s    = bus.s_bit;
          m_left = kbits(bus.op_b);
          if (m_left == 0) begin
            m_state = M_DONE;
            m_res = p_res; m_dest = p_dest; m_stb = p_stb;
          end else begin
            m_state = M_RUN;
          end
        end
        M_RUN: begin
          m_left--;
          if (m_left == 0) begin
            m_state = M_DONE;
            m_res = p_res; m_dest = p_dest; m_stb = p_stb;
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  logic e_done;
  always @(negedge clk) begin
    if (chk_en) begin
      e_done = (m_state == M_DONE) && !bus.flush;
      chk("busy", 64'(bus.busy), 64'(m_state != M_IDLE));
      chk("freeze", 64'(bus.freeze),
          64'((m_state == M_IDLE && bus.start && !bus.flush)
              || m_state == M_RUN));
      chk("done", 64'(bus.done), 64'(e_done));
      chk("status_we", 64'(bus.status_we), 64'(e_done && m_s));
      chk("result", 64'(bus.result), 64'(m_res));
      chk("dest_out", 64'(bus.dest_out), 64'(m_dest));
      chk("status_bits", 64'(bus.status_bits), 64'(m_stb));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the DONE cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input bit acc,
                        input bit s, input logic [3:0] d,
                        input logic [3:0] st, input bit hold,
                        output int lat, output logic [31:0] res,
                        output logic [3:0] dst, output logic [3:0] stb,
                        output bit swe, output int frz);
    bus.op_a = a; bus.op_b = b; bus.acc_in = c;
    bus.accumulate = acc; bus.s_bit = s;
    bus.dest_in = d; bus.status_in = st;
    bus.start = 1'b1;
    lat = -1; frz = 0; res = '0; dst = '0; stb = '0; swe = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i; res = bus.result; dst = bus.dest_out;
        stb = bus.status_bits; swe = bus.status_we;
        break;
      end
      if (bus.freeze) frz++;
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  int          lat, frz;
  logic [31:0] res, a, b, c;
  logic [3:0]  dst, stb;
  bit          swe, acc, s;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.flush = 0; bus.accumulate = 0; bus.s_bit = 0;
    bus.op_a = 0; bus.op_b = 0; bus.acc_in = 0;
    bus.dest_in = 0; bus.status_in = 0;
    #12;
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_freeze", 64'(bus.freeze), 0);
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_result", 64'(bus.result), 0);
    chk("rst_status_bits", 64'(bus.status_bits), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_op(3, 5, 0, 0, 1, 4'hA, 4'b1011, 0,
           lat, res, dst, stb, swe, frz);
    chk("mul35_lat", 64'(lat), 4);
    chk("mul35_res", 64'(res), 15);
    chk("mul35_dest", 64'(dst), 64'hA);
    chk("mul35_stb", 64'(stb), 64'b0011);
    chk("mul35_swe", 64'(swe), 1);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 4'h3, 4'b0000, 0,
           lat, res, dst, stb, swe, frz);
    chk("maxmul_lat", 64'(lat), 33);
    chk("maxmul_res", 64'(res), 1);
    chk("maxmul_stb", 64'(stb), 0);

    run_op(32'h80000000, 1, 0, 0, 1, 4'h5, 4'b0110, 0,
           lat, res, dst, stb, swe, frz);
    chk("msb_lat", 64'(lat), 2);
    chk("msb_res", 64'(res), 64'h80000000);
    chk("msb_stb", 64'(stb), 64'b1010);

    run_op(32'h1234, 0, 0, 1, 1, 4'h1, 4'b0000, 0,
           lat, res, dst, stb, swe, frz);
    chk("zero_lat", 64'(lat), 1);
    chk("zero_res", 64'(res), 0);
    chk("zero_stb", 64'(stb), 64'b0100);
    chk("zero_swe", 64'(swe), 1);
    run_op(32'h1234, 0, 0, 1, 0, 4'h1, 4'b0000, 0,
           lat, res, dst, stb, swe, frz);
    chk("zero_nos_swe", 64'(swe), 0);

    run_op(7, 6, 100, 1, 1, 4'h7, 4'b0001, 1,
           lat, res, dst, stb, swe, frz);
    chk("mla_lat", 64'(lat), 4);
    chk("mla_res", 64'(res), 142);
    chk("mla_frz", 64'(frz), 4);
    chk("mla_idle_after", 64'(bus.busy), 0);

    // flush on the 2nd RUN cycle
    bus.op_a = 32'h55; bus.op_b = 32'hFF; bus.accumulate = 0;
    bus.s_bit = 1; bus.dest_in = 4'h9; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_done", 64'(bus.done), 0);
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(bus.busy), 0);
    chk("flush_done2", 64'(bus.done), 0);
    @(posedge clk); #1;
    run_op(5, 9, 0, 0, 1, 4'h2, 4'b0000, 0,
           lat, res, dst, stb, swe, frz);
    chk("after_flush_lat", 64'(lat), 5);
    chk("after_flush_res", 64'(res), 45);

    // start and flush together in IDLE
    bus.start = 1'b1; bus.flush = 1'b1; bus.op_b = 3;
    @(negedge clk);
    chk("sf_freeze", 64'(bus.freeze), 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("sf_busy", 64'(bus.busy), 0);
    @(posedge clk); #1;

    // async reset mid-RUN
    bus.op_a = 32'h1234; bus.op_b = 32'hFFFF; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 0);
    chk("arst_freeze", 64'(bus.freeze), 0);
    chk("arst_result", 64'(bus.result), 0);
    chk("arst_dest", 64'(bus.dest_out), 0);
    chk("arst_stb", 64'(bus.status_bits), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    run_op(2, 2, 0, 0, 1, 4'h4, 4'b0000, 0,
           lat, res, dst, stb, swe, frz);
    chk("post_rst_lat", 64'(lat), 3);
    chk("post_rst_res", 64'(res), 4);

    // random ops
    for (int n = 0; n < 40; n++) begin
      a = $urandom();
      b = $urandom() >> $urandom_range(0, 32);
      c = $urandom();
      acc = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      run_op(a, b, c, acc, s, 4'($urandom()), 4'($urandom()),
             1'($urandom_range(0, 1)), lat, res, dst, stb, swe, frz);
      chk("rnd_lat", 64'(lat), 64'(b == 0 ? 1 : kbits(b) + 1));
      chk("rnd_res", 64'(res), 64'(ref_mul(a, b, c, acc)));
    end

    // random flushes
    for (int n = 0; n < 20; n++) begin
      bus.op_a = $urandom();
      bus.op_b = $urandom() >> $urandom_range(0, 31);
      bus.acc_in = $urandom();
      bus.accumulate = 1'($urandom_range(0, 1));
      bus.s_bit = 1'($urandom_range(0, 1));
      bus.dest_in = 4'($urandom());
      bus.status_in = 4'($urandom());
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
